bus_if: RTL and testbench
=========================

# bus_if

Bus interface unit between one CPU pipeline stage (IF or MEM) and the shared system bus. It takes a single-word access request from the stage, arbitrates for the bus, runs the address/data handshake, and returns read data. It produces the `busy` indication consumed by the CPU control unit as `if_busy`/`mem_busy`, and honours that unit's `stall`/`flush` outputs. It is the producer side of the busy/stall/flush protocol.

## Interface
- `TIMEOUT_CYCLES`, default 255: ACCESS cycles without `bus_rdy_` before abort. Only used with `BUS_TIMEOUT_EN`. Must be ≥2 and fit in 8 bits.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: stage stall from the control unit.
- `flush` in 1: stage flush from the control unit.
- `addr` in 30: word address of the access.
- `as_` in 1: access strobe, active-low.
- `rw` in 1: 1 = read, 0 = write.
- `wr_data` in 32: write data.
- `rd_data` out 32: read data returned to the stage.
- `busy` out 1: access in progress; the stage must hold.
- `bus_err` out 1: one-cycle pulse on access timeout.
- `bus_req_` out 1: bus request to the arbiter, active-low.
- `bus_grnt_` in 1: grant from the arbiter, active-low.
- `bus_addr` out 30: bus address.
- `bus_as_` out 1: bus address strobe, active-low.
- `bus_rw` out 1: bus direction, 1 = read.
- `bus_wr_data` out 32: bus write data.
- `bus_rd_data` in 32: bus read data.
- `bus_rdy_` in 1: slave ready, active-low.

## Operation
- **Reset values:** state IDLE, `bus_req_`=1, `bus_as_`=1, `bus_rw`=1, `bus_addr`=0, `bus_wr_data`=0, `rd_buf`=0, `bus_err`=0, timeout count 0.
- **States:** IDLE, REQ, ACCESS, STALL.
- **IDLE:**
  - With `as_`=0 and `flush`=0: `busy`=1 combinationally. Register `bus_req_`=0 and go to REQ.
  - Otherwise `busy`=0 and `rd_data`=`rd_buf`.
- **REQ:** `busy`=1.
  - If `flush`=1: set `bus_req_`=1 and go to IDLE. Flush takes priority over grant.
  - Else, when `bus_grnt_`=0: register `bus_addr`=`addr`, `bus_rw`=`rw`, `bus_wr_data`=`wr_data`, `bus_as_`=0, and go to ACCESS.
- **ACCESS:** `bus_as_` returns to 1 after exactly one cycle.
  - While `bus_rdy_`=1: `busy`=1.
  - On the cycle `bus_rdy_`=0: `busy`=0 and `rd_data`=`bus_rd_data` (combinational pass-through). Capture `bus_rd_data` into `rd_buf` and set `bus_req_`=1. Go to STALL if `stall`=1, else IDLE.
  - `flush` during ACCESS does not abort the bus cycle. The transfer completes and the result is still captured.
- **STALL:** `busy`=0, `rd_data`=`rd_buf`. Return to IDLE when `stall`=0.
- **Write data:** on writes, `rd_data` is don't-care but deterministic (`rd_buf` updated from `bus_rd_data`).
- **Reset mid-access:** all outputs return to reset values immediately (asynchronous), including releasing `bus_req_` and `bus_as_`.

## Timing
- **Latency with immediate grant and rdy in the first ACCESS cycle:** 2 cycles from `as_`=0 to `busy`=0.
  - Request cycle: IDLE→REQ.
  - Grant cycle: REQ→ACCESS.
  - Rdy cycle: data returned.
- `busy` is combinational from state, `as_`, `flush` and `bus_rdy_`. All `bus_*` outputs are registered.
- A new request may be accepted in the IDLE cycle directly after completion. Back-to-back throughput is 1 access per 3 cycles.

## Configuration
- **`BUS_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `bus_rdy_`=1.
  - When it reaches `TIMEOUT_CYCLES`, that cycle: `bus_err`=1, `busy`=0, `rd_data`=0, `bus_req_`←1, and state goes to IDLE. `rd_buf` is not updated.
  - If `bus_rdy_`=0 arrives in the same cycle, rdy wins and no error is raised.
- **`BUS_TIMEOUT_EN` undefined:** no counter; `bus_err` is tied to 0; ACCESS waits indefinitely.

## Structure
- **Shared CPU package:** `WORD`/`WORD_ADDR_W` widths, `READ`=1/`WRITE`=0, active-low `ENABLE_`=0/`DISABLE_`=1, and the state encoding (2 bits).
- **Sub-modules:** none required. The timeout counter stays inline.

## Test plan
- **Reset:** hold `reset`=0 → `bus_req_`=1, `bus_as_`=1, `busy`=0, `rd_data`=0. Release → same.
- **Read:**
  - Stimulus: `addr`=0x0000_0004, `rw`=1, `as_`=0; grant next cycle; `bus_rdy_`=0 with `bus_rd_data`=0xDEAD_BEEF in the first ACCESS cycle.
  - Expected: `busy` high for 2 cycles; `bus_addr`=4 with `bus_as_`=0 for 1 cycle; `rd_data`=0xDEAD_BEEF.
- **Write:** `rw`=0, `wr_data`=0x1234_5678, grant delayed 3 cycles → `bus_wr_data`=0x1234_5678 and `bus_rw`=0 on the ACCESS cycle; `busy` high for 5 cycles.
- **Flush in REQ:** `flush`=1 with `bus_grnt_`=1 → IDLE next cycle, `bus_req_`=1, `bus_as_` never asserted.
- **Stall hold:** `stall`=1 during completion, `bus_rd_data` changes afterwards → `rd_data` stays 0xDEAD_BEEF until `stall`=0.
- **Timeout (`BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** never assert `bus_rdy_` → `bus_err` pulses 1 cycle after 4 ACCESS cycles, `rd_data`=0, `bus_req_`=1. Repeat with rdy on that exact cycle → no `bus_err`.

Source files
------------

// File: rtl/bus_if_pkg.sv
// -----------------------------------------------------------------------------
// bus_if_pkg
// Shared CPU definitions used by the bus interface unit:
//   - word / word-address widths
//   - read/write direction encoding
//   - active-low enable/disable levels for the *_ strobes
//   - bus interface state encoding (2 bits)
// -----------------------------------------------------------------------------
package bus_if_pkg;

    localparam int WORD_W      = 32;
    localparam int WORD_ADDR_W = 30;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        BUS_IF_IDLE   = 2'd0,
        BUS_IF_REQ    = 2'd1,
        BUS_IF_ACCESS = 2'd2,
        BUS_IF_STALL  = 2'd3
    } bus_if_state_t;

endpackage

// File: rtl/bus_if.sv
// -----------------------------------------------------------------------------
// bus_if
// Bus interface unit between one CPU pipeline stage and the shared system bus.
// Accepts a single-word request from the stage, requests the bus from the
// arbiter, runs the address/data handshake and hands back read data.
//
// Parameters:
//   TIMEOUT_CYCLES  ACCESS cycles without slave ready before the access is
//                   abandoned (2..255). Only meaningful with BUS_TIMEOUT_EN.
//
// Optional feature macro:
//   BUS_TIMEOUT_EN  enables the ACCESS watchdog and the bus_err pulse.
//                   Without it bus_err is constant 0 and ACCESS waits forever.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   stall, flush      stage control from the CPU control unit
//   addr, as_, rw,    stage request: word address, strobe (active-low),
//   wr_data           direction (1 = read), write data
//   rd_data, busy     read data to the stage, stage must hold while busy
//   bus_err           one-cycle pulse on an access timeout
//   bus_req_,         arbiter request (active-low) / grant (active-low)
//   bus_grnt_
//   bus_addr, bus_as_,bus address phase (registered)
//   bus_rw,
//   bus_wr_data
//   bus_rd_data,      slave read data / ready (active-low)
//   bus_rdy_
// -----------------------------------------------------------------------------
module bus_if
    import bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_W-1:0]      wr_data,
    output logic [WORD_W-1:0]      rd_data,
    output logic                   busy,
    output logic                   bus_err,
    output logic                   bus_req_,
    input  logic                   bus_grnt_,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_W-1:0]      bus_wr_data,
    input  logic [WORD_W-1:0]      bus_rd_data,
    input  logic                   bus_rdy_
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
        $error("bus_if: TIMEOUT_CYCLES must be in 2..255");
    end

    bus_if_state_t          state_r, state_s;
    logic                   bus_req_r, bus_req_s;
    logic                   bus_as_r, bus_as_s;
    logic                   bus_rw_r, bus_rw_s;
    logic [WORD_ADDR_W-1:0] bus_addr_r, bus_addr_s;
    logic [WORD_W-1:0]      bus_wr_data_r, bus_wr_data_s;
    logic [WORD_W-1:0]      rd_buf_r, rd_buf_s;
    logic                   timeout_s;

`ifdef BUS_TIMEOUT_EN
    // The watchdog fires on the ACCESS cycle whose increment would reach the
    // limit, so that cycle itself reports the error and releases the bus.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_r, tmo_cnt_s;

    // Watchdog counter: zero outside ACCESS, counts not-ready ACCESS cycles.
    always_comb begin
        tmo_cnt_s = 8'd0;
        timeout_s = 1'b0;
        if (state_r == BUS_IF_ACCESS && bus_rdy_ == DISABLE_) begin
            if (tmo_cnt_r == TMO_LAST) begin
                timeout_s = 1'b1;
            end else begin
                tmo_cnt_s = tmo_cnt_r + 8'd1;
            end
        end else begin
            tmo_cnt_s = 8'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_r <= 8'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_s;
        end
    end

    assign bus_err = timeout_s;
`else
    assign timeout_s = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Next-state, next bus-register values and the combinational stage outputs.
    always_comb begin
        state_s       = state_r;
        bus_req_s     = bus_req_r;
        bus_as_s      = bus_as_r;
        bus_rw_s      = bus_rw_r;
        bus_addr_s    = bus_addr_r;
        bus_wr_data_s = bus_wr_data_r;
        rd_buf_s      = rd_buf_r;
        busy          = 1'b0;
        rd_data       = rd_buf_r;

        case (state_r)
            BUS_IF_IDLE: begin
                if (as_ == ENABLE_ && !flush) begin
                    busy      = 1'b1;
                    bus_req_s = ENABLE_;
                    state_s   = BUS_IF_REQ;
                end else begin
                    busy = 1'b0;
                end
            end

            BUS_IF_REQ: begin
                busy = 1'b1;
                // Flush wins over a grant arriving in the same cycle.
                if (flush) begin
                    bus_req_s = DISABLE_;
                    state_s   = BUS_IF_IDLE;
                end else if (bus_grnt_ == ENABLE_) begin
                    bus_addr_s    = addr;
                    bus_rw_s      = rw;
                    bus_wr_data_s = wr_data;
                    bus_as_s      = ENABLE_;
                    state_s       = BUS_IF_ACCESS;
                end else begin
                    state_s = BUS_IF_REQ;
                end
            end

            BUS_IF_ACCESS: begin
                // Address strobe is a single-cycle pulse; flush is ignored here
                // so a started bus cycle always runs to completion.
                bus_as_s = DISABLE_;
                if (bus_rdy_ == ENABLE_) begin
                    busy      = 1'b0;
                    rd_data   = bus_rd_data;
                    rd_buf_s  = bus_rd_data;
                    bus_req_s = DISABLE_;
                    state_s   = stall ? BUS_IF_STALL : BUS_IF_IDLE;
                end else if (timeout_s) begin
                    busy      = 1'b0;
                    rd_data   = {WORD_W{1'b0}};
                    bus_req_s = DISABLE_;
                    state_s   = BUS_IF_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end

            BUS_IF_STALL: begin
                if (!stall) begin
                    state_s = BUS_IF_IDLE;
                end else begin
                    state_s = BUS_IF_STALL;
                end
            end

            default: begin
                state_s = BUS_IF_IDLE;
            end
        endcase
    end

    // State and bus-side registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= BUS_IF_IDLE;
            bus_req_r     <= DISABLE_;
            bus_as_r      <= DISABLE_;
            bus_rw_r      <= READ;
            bus_addr_r    <= {WORD_ADDR_W{1'b0}};
            bus_wr_data_r <= {WORD_W{1'b0}};
            rd_buf_r      <= {WORD_W{1'b0}};
        end else begin
            state_r       <= state_s;
            bus_req_r     <= bus_req_s;
            bus_as_r      <= bus_as_s;
            bus_rw_r      <= bus_rw_s;
            bus_addr_r    <= bus_addr_s;
            bus_wr_data_r <= bus_wr_data_s;
            rd_buf_r      <= rd_buf_s;
        end
    end

    assign bus_req_    = bus_req_r;
    assign bus_as_     = bus_as_r;
    assign bus_rw      = bus_rw_r;
    assign bus_addr    = bus_addr_r;
    assign bus_wr_data = bus_wr_data_r;

endmodule

// File: tb/tb_bus_if.sv
// -----------------------------------------------------------------------------
// tb_bus_if
// Randomized, self-checking bench for bus_if. A transaction-level model tracks
// where the current stage access is in its life (waiting for the bus, on the
// bus, held by stall) and predicts every output each cycle; directed sections
// pin the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_bus_if;

    localparam int TMO = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, as_, rw;
    logic [29:0] addr;
    logic [31:0] wr_data, rd_data;
    logic        busy, bus_err, bus_req_, bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_, bus_rw;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic        bus_rdy_;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    bus_if #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy), .bus_err(bus_err),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_wait, m_xfer, m_hold;
    int          m_age;
    logic        m_req_, m_as_, m_rw;
    logic [29:0] m_addr;
    logic [31:0] m_wd, m_buf;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_wait <= 1'b0; m_xfer <= 1'b0; m_hold <= 1'b0; m_age <= 0;
            m_req_ <= 1'b1; m_as_ <= 1'b1; m_rw <= 1'b1;
            m_addr <= 30'd0; m_wd <= 32'd0; m_buf <= 32'd0;
        end else if (m_hold) begin
            if (!stall) m_hold <= 1'b0;
        end else if (m_xfer) begin
            m_as_ <= 1'b1;
            if (!bus_rdy_) begin
                m_buf <= bus_rd_data; m_req_ <= 1'b1; m_xfer <= 1'b0; m_hold <= stall;
            end else if (TO_EN && (m_age + 1 == TMO)) begin
                m_req_ <= 1'b1; m_xfer <= 1'b0;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_wait) begin
            if (flush) begin
                m_req_ <= 1'b1; m_wait <= 1'b0;
            end else if (!bus_grnt_) begin
                m_addr <= addr; m_rw <= rw; m_wd <= wr_data; m_as_ <= 1'b0;
                m_wait <= 1'b0; m_xfer <= 1'b1; m_age <= 0;
            end
        end else if (!as_ && !flush) begin
            m_req_ <= 1'b0; m_wait <= 1'b1;
        end
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin
        logic        e_busy, e_err;
        logic [31:0] e_rd;
        if (cmp_en) begin
            e_err = 1'b0;
            e_rd  = m_buf;
            if (m_hold) begin
                e_busy = 1'b0;
            end else if (m_xfer) begin
                e_err  = bus_rdy_ && TO_EN && (m_age + 1 == TMO);
                e_busy = bus_rdy_ && !e_err;
                if (!bus_rdy_) e_rd = bus_rd_data;
                else if (e_err) e_rd = 32'd0;
            end else if (m_wait) begin
                e_busy = 1'b1;
            end else begin
                e_busy = !as_ && !flush;
            end
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("bus_err", {31'd0, bus_err}, {31'd0, e_err});
            if (!e_busy) check("rd_data", rd_data, e_rd);
            check("bus_req_", {31'd0, bus_req_}, {31'd0, m_req_});
            check("bus_as_", {31'd0, bus_as_}, {31'd0, m_as_});
            check("bus_rw", {31'd0, bus_rw}, {31'd0, m_rw});
            check("bus_addr", {2'd0, bus_addr}, {2'd0, m_addr});
            check("bus_wr_data", bus_wr_data, m_wd);
        end
    end

    // One stage access with an always-ready slave; called just after a rising
    // edge. Grant is withheld for gdelay REQ cycles.
    task automatic xfer(input logic r, input logic [29:0] a, input logic [31:0] wd,
                        input logic [31:0] rdv, input int gdelay, input logic st,
                        output int busy_n, output int as_n, output logic [31:0] rd_got,
                        output logic [29:0] a_seen, output logic rw_seen,
                        output logic [31:0] wd_seen);
        as_ = 1'b0; rw = r; addr = a; wr_data = wd; bus_grnt_ = 1'b1;
        bus_rdy_ = 1'b0; bus_rd_data = rdv; stall = st; flush = 1'b0;
        busy_n = 0; as_n = 0; rd_got = 32'hxxxx_xxxx;
        a_seen = 30'd0; rw_seen = 1'b1; wd_seen = 32'd0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_as_ == 1'b0) begin
                as_n++; a_seen = bus_addr; rw_seen = bus_rw; wd_seen = bus_wr_data;
            end
            if (busy) begin
                busy_n++;
            end else begin
                rd_got = rd_data;
                break;
            end
            @(posedge clk); #1;
            if (c >= gdelay) bus_grnt_ = 1'b0;
        end
        @(posedge clk); #1;
        as_ = 1'b1; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    endtask

    initial begin
        int          bn, an, k, err_at;
        logic [31:0] rg, wds;
        logic [29:0] as_addr;
        logic        rws;

        reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
        addr = 30'd0; wr_data = 32'd0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
        bus_rd_data = 32'd0;
        #1 reset = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset held, then released.
        @(negedge clk);
        check("rst_req", {31'd0, bus_req_}, 32'd1);
        check("rst_as", {31'd0, bus_as_}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rel_req", {31'd0, bus_req_}, 32'd1);
        check("rel_as", {31'd0, bus_as_}, 32'd1);
        check("rel_busy", {31'd0, busy}, 32'd0);
        check("rel_rd", rd_data, 32'd0);
        @(posedge clk); #1;

        // Read with immediate grant and ready.
        xfer(1'b1, 30'h4, 32'd0, 32'hDEAD_BEEF, 0, 1'b0, bn, an, rg, as_addr, rws, wds);
        check("rd_busy_cycles", bn, 32'd2);
        check("rd_as_cycles", an, 32'd1);
        check("rd_bus_addr", {2'd0, as_addr}, 32'd4);
        check("rd_data_ret", rg, 32'hDEAD_BEEF);

        // Write with grant delayed by three cycles.
        xfer(1'b0, 30'h155, 32'h1234_5678, 32'h0, 3, 1'b0, bn, an, rg, as_addr, rws, wds);
        check("wr_busy_cycles", bn, 32'd5);
        check("wr_bus_wr_data", wds, 32'h1234_5678);
        check("wr_bus_rw", {31'd0, rws}, 32'd0);

        // Stall at completion holds the returned word.
        xfer(1'b1, 30'h8, 32'd0, 32'hDEAD_BEEF, 0, 1'b1, bn, an, rg, as_addr, rws, wds);
        check("st_rd_ret", rg, 32'hDEAD_BEEF);
        bus_rd_data = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("st_hold_rd", rd_data, 32'hDEAD_BEEF);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        check("st_release_rd", rd_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Flush while waiting for grant.
        as_ = 1'b0; rw = 1'b1;
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("fl_busy_req", {31'd0, busy}, 32'd1);
        @(posedge clk); #1 flush = 1'b0; as_ = 1'b1;
        @(negedge clk);
        check("fl_req_released", {31'd0, bus_req_}, 32'd1);
        check("fl_as_idle", {31'd0, bus_as_}, 32'd1);
        check("fl_busy_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an access.
        as_ = 1'b0; bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mr_as_active", {31'd0, bus_as_}, 32'd0);
        #2 reset = 1'b0;
        #1;
        check("mr_as_released", {31'd0, bus_as_}, 32'd1);
        check("mr_req_released", {31'd0, bus_req_}, 32'd1);
        #1 reset = 1'b1; as_ = 1'b1; bus_grnt_ = 1'b1;
        @(posedge clk); #1;

`ifdef BUS_TIMEOUT_EN
        // Watchdog: no ready ever, then ready on exactly the limit cycle.
        for (int pass = 0; pass < 2; pass++) begin
            as_ = 1'b0; rw = 1'b1; bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
            bus_rd_data = 32'hCAFE_0000 + pass;
            err_at = -1;
            for (k = 0; k < 12; k++) begin
                @(negedge clk);
                if (bus_err && err_at < 0) begin
                    err_at = k;
                    check("to_rd_zero", rd_data, 32'd0);
                end
                if (!busy) break;
                @(posedge clk); #1;
                if (k == TMO && pass == 1) bus_rdy_ = 1'b0;
            end
            if (pass == 0) check("to_err_cycle", err_at, TMO + 1);
            else check("to_rdy_wins", err_at, 32'hFFFF_FFFF);
            @(posedge clk); #1 as_ = 1'b1; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
            @(negedge clk);
            check("to_req_released", {31'd0, bus_req_}, 32'd1);
            @(posedge clk); #1;
        end
`endif

        // Randomized traffic, occasionally with a short reset pulse.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            as_         = ($urandom_range(0, 1) == 0);
            rw          = 1'($urandom_range(0, 1));
            addr        = 30'($urandom);
            wr_data     = $urandom;
            bus_grnt_   = ($urandom_range(0, 9) < 4);
            bus_rdy_    = ($urandom_range(0, 9) < 6);
            bus_rd_data = $urandom;
            stall       = ($urandom_range(0, 9) < 3);
            flush       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0; #2 reset = 1'b1;
            end
        end

        @(posedge clk); #1;
        as_ = 1'b1; flush = 1'b0; stall = 1'b0; bus_rdy_ = 1'b0;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
